// File: rtl/storage_arb_pkg.sv
// -----------------------------------------------------------------------------
// storage_arb_pkg
// Shared types and constants for the storage request arbiter.
//   arb_state_t      : arbiter FSM state (IDLE, ACCESS, RESP)
//   DEF_MEM_W        : default data bus width
//   DEF_ADDR_W       : default address width
//   DEF_TIMEOUT_CYC  : default downstream wait limit (used only when
//                      STORAGE_ARB_TIMEOUT_EN is defined)
//   ptr_width()      : index width for n requesters, never below 1 bit
// -----------------------------------------------------------------------------
package storage_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam int DEF_MEM_W       = 32;
   localparam int DEF_ADDR_W      = 32;
   localparam int DEF_TIMEOUT_CYC = 1024;

   function automatic int ptr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: selects the first asserted valid at or after
// ptr, wrapping modulo NUM_REQ. Holds no state; the pointer lives in the caller.
// Ports:
//   valid     in  NUM_REQ  request vector
//   ptr       in  PTR_W    index with highest priority this cycle
//   grant     out NUM_REQ  one-hot pick (zero when nothing is valid)
//   grant_idx out PTR_W    index of the pick (zero when nothing is valid)
//   any_valid out 1        at least one valid bit set
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               any_valid
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      // Walk offsets from the pointer; the first hit wins and blocks the rest.
      for (int off = 0; off < NUM_REQ; off++) begin
         if (!any_valid && valid[(int'(ptr) + off) % NUM_REQ]) begin
            any_valid                              = 1'b1;
            grant[(int'(ptr) + off) % NUM_REQ]     = 1'b1;
            grant_idx                              = PTR_W'((int'(ptr) + off) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/storage_req_arbiter.sv
// -----------------------------------------------------------------------------
// storage_req_arbiter
// Shares one storage-controller port between NUM_REQ requesters using
// round-robin arbitration with a single outstanding access. The granted
// request is latched, presented downstream until mem_done, and the result is
// returned as a one-cycle rsp_valid pulse to the granted requester.
//
// Optional feature (macro STORAGE_ARB_TIMEOUT_EN): a wait counter aborts an
// access that has not completed after TIMEOUT_CYC cycles and answers with
// rsp_err=1, rsp_rdata=0. Without the macro the FSM waits indefinitely and
// rsp_err is constant 0.
//
// Handshake: a request is taken in the cycle req_valid[i] and req_ready[i] are
// both high; req_ready is a combinational one-hot pulse issued only in IDLE.
// A requester must hold req_* stable while req_valid is high and req_ready low;
// anything it does after the accept cycle is ignored until the next grant.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready/we       per-requester handshake and write flag
//   req_addr/wdata/be        packed per-requester payload (slot i at i*W)
//   rsp_valid                one-hot completion pulse
//   rsp_rdata, rsp_err       shared response, qualified by rsp_valid
//   mem_access/we/addr/wdata/be  downstream access, held until completion
//   mem_done, mem_rdata      downstream completion pulse and read data
//   busy                     FSM not in IDLE
// -----------------------------------------------------------------------------
module storage_req_arbiter
   import storage_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int MEM_W       = DEF_MEM_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ*MEM_W-1:0]      req_wdata,
   input  logic [NUM_REQ*(MEM_W/8)-1:0]  req_be,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [MEM_W-1:0]              rsp_rdata,
   output logic                          rsp_err,
   output logic                          mem_access,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [MEM_W-1:0]              mem_wdata,
   output logic [MEM_W/8-1:0]            mem_be,
   input  logic                          mem_done,
   input  logic [MEM_W-1:0]              mem_rdata,
   output logic                          busy
);

   localparam int BE_W  = MEM_W / 8;
   localparam int PTR_W = ptr_width(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("storage_req_arbiter: unsupported parameter set");
   end

   // FSM state is kept as a named enum so checkers can bind to it directly.
   arb_state_t         state;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   gnt_q;
   logic [NUM_REQ-1:0] pick;
   logic [PTR_W-1:0]   pick_idx;
   logic               any_valid;
   logic               accept;

   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [MEM_W-1:0]   sel_wdata;
   logic [BE_W-1:0]    sel_be;

`ifdef STORAGE_ARB_TIMEOUT_EN
   localparam int CNT_W = ptr_width(TIMEOUT_CYC);
   logic [CNT_W-1:0] tmo_cnt;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .valid     (req_valid),
      .ptr       (ptr),
      .grant     (pick),
      .grant_idx (pick_idx),
      .any_valid (any_valid)
   );

   // An accept coinciding with reset would be discarded, so it is not signalled.
   assign accept    = (state == IDLE) && any_valid && !rst;
   assign req_ready = accept ? pick : '0;
   assign busy      = (state != IDLE);

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*MEM_W +: MEM_W];
            sel_be    = req_be[i*BE_W +: BE_W];
         end
      end
   end

   // The mem_* registers double as the latch of the granted request, so the
   // downstream view is stable for the whole ACCESS state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         gnt_q      <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         mem_access <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
`ifdef STORAGE_ARB_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  gnt_q      <= pick_idx;
                  mem_we     <= sel_we;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_be     <= sel_be;
                  mem_access <= 1'b1;
`ifdef STORAGE_ARB_TIMEOUT_EN
                  tmo_cnt    <= '0;
`endif
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               // mem_done in the expiry cycle takes priority over the timeout.
               if (mem_done) begin
                  rsp_rdata  <= mem_we ? '0 : mem_rdata;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= NUM_REQ'(1) << gnt_q;
                  mem_access <= 1'b0;
                  state      <= RESP;
               end
`ifdef STORAGE_ARB_TIMEOUT_EN
               else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  rsp_rdata  <= '0;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= NUM_REQ'(1) << gnt_q;
                  mem_access <= 1'b0;
                  state      <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               rsp_valid <= '0;
               ptr       <= (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_storage_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_storage_req_arbiter
// Bench for storage_req_arbiter with three requesters. A transaction-level
// reference model (arbitration pointer, accept/response latency, expected
// response queue) predicts every output each cycle. Directed scenarios are
// followed by a randomized phase. With STORAGE_ARB_TIMEOUT_EN defined the
// timeout scenarios run as well (TIMEOUT_CYC = 16).
// -----------------------------------------------------------------------------
module tb_storage_req_arbiter;
   import storage_arb_pkg::*;

   localparam int N   = 3;
   localparam int MW  = 32;
   localparam int AW  = 32;
   localparam int BW  = MW / 8;
   localparam int TMO = 16;
`ifdef STORAGE_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_we = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*MW-1:0] req_wdata = '0;
   logic [N*BW-1:0] req_be = '0;
   logic [N-1:0]    rsp_valid;
   logic [MW-1:0]   rsp_rdata;
   logic            rsp_err;
   logic            mem_access;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [MW-1:0]   mem_wdata;
   logic [BW-1:0]   mem_be;
   logic            mem_done = 1'b0;
   logic [MW-1:0]   mem_rdata = '0;
   logic            busy;

   storage_req_arbiter #(
      .NUM_REQ     (N),
      .MEM_W       (MW),
      .ADDR_W      (AW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_access (mem_access),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_done   (mem_done),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   // ------------------------------------------------------------ requester state
   logic          rv[N];
   logic          rwe[N];
   logic [AW-1:0] raddr[N];
   logic [MW-1:0] rwdata[N];
   logic [BW-1:0] rbe[N];
   bit            refill[N];
   bit            rand_mode = 1'b0;
   bit            spurious  = 1'b0;
   bit            rst_next  = 1'b1;
   int            next_k    = -1;
   bit            rd_ov     = 1'b0;
   logic [MW-1:0] rd_ov_val = '0;

   // ------------------------------------------------------------ reference model
   // age: cycles since accept (-1 = no transaction). mem_access is expected for
   // ages 1..end_at, the response at end_at+1, and arbitration resumes after.
   int            age    = -1;
   int            done_at = 0;
   int            end_at  = 0;
   int            ptr     = 0;
   int            g       = 0;
   logic          t_we;
   logic [AW-1:0] t_addr;
   logic [MW-1:0] t_wdata;
   logic [BW-1:0] t_be;
   logic [MW-1:0] t_rd;
   bit            t_err;
   logic [MW-1:0] exp_q[$];

   // ---------------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_err    = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- driver tasks
   task automatic new_req(input int i);
      rv[i]     = 1'b1;
      rwe[i]    = 1'($urandom_range(0, 1));
      raddr[i]  = $urandom;
      rwdata[i] = $urandom;
      rbe[i]    = BW'($urandom_range(0, 15));
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [MW-1:0] d, input logic [BW-1:0] be);
      rv[i]     = 1'b1;
      rwe[i]    = we;
      raddr[i]  = a;
      rwdata[i] = d;
      rbe[i]    = be;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         rv[i]     = 1'b0;
         refill[i] = 1'b0;
      end
   endtask

   // One clock cycle: drive at negedge, compare just after, advance the model.
   task automatic cycle();
      logic [N-1:0] one;
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_rsp;
      logic [MW-1:0] exp_rd;
      bit           exp_acc;
      bit           spur;
      int           pick;
      int           k;
      one = 1;
      @(negedge clk);
      rst = rst_next;
      if (rand_mode) begin
         for (int i = 0; i < N; i++) begin
            if (!rv[i]) begin
               if ($urandom_range(0, 2) == 0) new_req(i);
            end else if ($urandom_range(0, 15) == 0) begin
               rv[i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         req_valid[i]             = rv[i];
         req_we[i]                = rwe[i];
         req_addr[i*AW +: AW]     = raddr[i];
         req_wdata[i*MW +: MW]    = rwdata[i];
         req_be[i*BW +: BW]       = rbe[i];
      end
      spur = spurious || (rand_mode && (age < 0 || age == end_at + 1) &&
                          $urandom_range(0, 9) == 0);
      mem_done  = spur || (age >= 1 && age == done_at && done_at <= end_at);
      mem_rdata = (age >= 1 && age == done_at) ? t_rd : $urandom;
      #1;

      pick = -1;
      if (age < 0 && !rst) begin
         for (int off = 0; off < N; off++) begin
            if (pick < 0 && rv[(ptr + off) % N]) pick = (ptr + off) % N;
         end
      end
      exp_rdy = (pick >= 0) ? (one << pick) : '0;
      check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));

      exp_acc = (age >= 1 && age <= end_at);
      check_eq("mem_access", 64'(mem_access), 64'(exp_acc));
      if (exp_acc) begin
         check_eq("mem_we",    64'(mem_we),    64'(t_we));
         check_eq("mem_addr",  64'(mem_addr),  64'(t_addr));
         check_eq("mem_wdata", 64'(mem_wdata), 64'(t_wdata));
         check_eq("mem_be",    64'(mem_be),    64'(t_be));
      end

      exp_rsp = (age >= 1 && age == end_at + 1) ? (one << g) : '0;
      check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      if (exp_rsp != '0) begin
         exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
         check_eq("rsp_err",   64'(rsp_err),   64'(t_err));
      end
      check_eq("busy", 64'(busy), 64'(age >= 1));

      if (rst) begin
         age = -1;
         ptr = 0;
         exp_q.delete();
      end else if (age >= 0) begin
         if (age == end_at + 1) begin
            age = -1;
            ptr = (g + 1) % N;
         end else begin
            age++;
         end
      end else if (pick >= 0) begin
         g       = pick;
         t_we    = rwe[g];
         t_addr  = raddr[g];
         t_wdata = rwdata[g];
         t_be    = rbe[g];
         k       = (next_k >= 0) ? next_k : $urandom_range(0, 5);
         done_at = 1 + k;
         t_err   = TMO_EN && (done_at > TMO);
         end_at  = t_err ? TMO : done_at;
         t_rd    = rd_ov ? rd_ov_val : $urandom;
         exp_q.push_back((t_we || t_err) ? '0 : t_rd);
         age     = 1;
         if (refill[g]) new_req(g);
         else rv[g] = 1'b0;
      end
   endtask

   // ------------------------------------------------------------------ stimulus
   initial begin
      clear_reqs();
      for (int i = 0; i < N; i++) begin
         rwe[i] = 1'b0; raddr[i] = '0; rwdata[i] = '0; rbe[i] = '0;
      end
      repeat (2) @(posedge clk);
      cycle();
      check_eq("rst_rsp_rdata",  64'(rsp_rdata),  64'(0));
      check_eq("rst_rsp_err",    64'(rsp_err),    64'(0));
      check_eq("rst_mem_addr",   64'(mem_addr),   64'(0));
      check_eq("rst_mem_access", 64'(mem_access), 64'(0));
      rst_next = 1'b0;

      // Single read with three wait cycles and a fixed read value.
      set_req(0, 1'b0, 32'h0000_0100, '0, 4'hF);
      rd_ov = 1'b1; rd_ov_val = 32'hDEAD_BEEF; next_k = 3;
      repeat (8) cycle();
      rd_ov = 1'b0;

      // Contention: requesters 0 and 1 always valid.
      set_req(0, 1'b0, 32'h0000_1000, '0, 4'hF);
      set_req(1, 1'b0, 32'h0000_1100, '0, 4'hF);
      refill[0] = 1'b1; refill[1] = 1'b1; next_k = 1;
      repeat (24) cycle();
      clear_reqs();
      repeat (6) cycle();

      // Write from requester 1.
      set_req(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
      next_k = 2;
      repeat (7) cycle();

      // Spurious completion while idle.
      spurious = 1'b1;
      cycle();
      spurious = 1'b0;
      repeat (2) cycle();

      // Reset in the middle of an access, then all three request.
      set_req(1, 1'b0, 32'h0000_3000, '0, 4'hF);
      next_k = 12;
      for (int c = 0; c < 10 && age != 3; c++) cycle();
      check_eq("rst_mid_age", 64'(age), 64'(3));
      rst_next = 1'b1;
      cycle();
      rst_next = 1'b0;
      for (int i = 0; i < N; i++) new_req(i);
      next_k = -1;
      repeat (20) cycle();
      clear_reqs();
      repeat (8) cycle();

`ifdef STORAGE_ARB_TIMEOUT_EN
      // No completion: abort after TMO cycles with an error response.
      set_req(2, 1'b0, 32'h0000_4000, '0, 4'hF);
      next_k = 1000;
      repeat (22) cycle();
      // Completion in the expiry cycle wins.
      set_req(2, 1'b0, 32'h0000_4004, '0, 4'hF);
      next_k = TMO - 1;
      repeat (22) cycle();
      next_k = -1;
`endif

      // Randomized traffic.
      rand_mode = 1'b1;
      repeat (3000) cycle();
      rand_mode = 1'b0;
      clear_reqs();
      repeat (12) cycle();
      check_eq("exp_q_empty", 64'(exp_q.size()), 64'(0));

      // ------------------------------------------------------------- report
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
